// File: rtl/arith_pkg.sv
// Shared types for the switch-driven add/subtract datapath.
package arith_pkg;
  localparam int DATA_W = 8;
  typedef logic signed [DATA_W-1:0] operand_t;
  typedef struct packed {
    logic     ovf;
    operand_t sum;
  } alu_out_t;
endpackage

// File: rtl/arith_addsub_if.sv
// Board-facing bundle: operand switches, mode button and LED result.
interface arith_addsub_if #(parameter int WIDTH = 8);
  logic [2*WIDTH-1:0] sw;
  logic               btnc;
  logic [WIDTH:0]     led;

  modport master (output sw, output btnc, input led);
  modport slave  (input sw, input btnc, output led);
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell of the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/arith_addsub_top.sv
// Two's-complement add/subtract: A=sw[7:0], B=sw[15:8], btnc selects A-B.
// led = {overflow, result}, optionally registered on clk.
module arith_addsub_top
  import arith_pkg::*;
#(
  parameter int WIDTH        = DATA_W,
  parameter bit REGISTER_OUT = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  arith_addsub_if.slave bus
);
  logic [WIDTH-1:0] a, b, b_eff, s;
  logic [WIDTH:0]   c;
  alu_out_t         res;

  assign a     = bus.sw[WIDTH-1:0];
  assign b     = bus.sw[2*WIDTH-1:WIDTH];
  // Subtract as A + ~B + 1: invert B and feed the mode bit in as carry.
  assign b_eff = b ^ {WIDTH{bus.btnc}};
  assign c[0]  = bus.btnc;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b_eff[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign res.sum = operand_t'(s);
  assign res.ovf = c[WIDTH] ^ c[WIDTH-1];

  if (REGISTER_OUT) begin : g_reg
    logic [WIDTH:0] led_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) led_q <= '0;
      else        led_q <= res;
    end
    assign bus.led = led_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign bus.led = res;
  end
endmodule

// File: tb/tb_arith_addsub_top.sv
// Checks combinational and registered variants against a signed integer model.
module tb_arith_addsub_top;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  always #5 clk = ~clk;

  arith_addsub_if #(.WIDTH(8)) if0 ();
  arith_addsub_if #(.WIDTH(8)) if1 ();

  arith_addsub_top #(.WIDTH(8), .REGISTER_OUT(1'b0)) u_comb (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  arith_addsub_top #(.WIDTH(8), .REGISTER_OUT(1'b1)) u_reg (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  function automatic logic [8:0] model(input logic [15:0] sw, input logic sub);
    operand_t   av, bv;
    int         r;
    logic [8:0] o;
    av = operand_t'(sw[7:0]);
    bv = operand_t'(sw[15:8]);
    r  = sub ? int'(av) - int'(bv) : int'(av) + int'(bv);
    o[7:0] = r[7:0];
    o[8]   = (r > 127) || (r < -128);
    return o;
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pop_exp(output logic [8:0] v);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_empty got=%0d exp=1", exp_q.size());
      v = 'x;
    end else begin
      v = exp_q.pop_front();
    end
  endtask

  task automatic comb_vec(input string tag, input logic [15:0] sw, input logic sub,
                          input logic [8:0] fixed, input bit use_fixed);
    if0.sw   = sw;
    if0.btnc = sub;
    exp_q.push_back(use_fixed ? fixed : model(sw, sub));
    #10;
    pop_exp(e);
    check(tag, if0.led, e);
  endtask

  task automatic reg_vec(input string tag, input logic [15:0] sw, input logic sub);
    @(negedge clk);
    if1.sw   = sw;
    if1.btnc = sub;
    exp_q.push_back(model(sw, sub));
    @(posedge clk);
    #1;
    pop_exp(e);
    check(tag, if1.led, e);
  endtask

  initial begin
    if0.sw = '0; if0.btnc = 1'b0;
    if1.sw = 16'h0305; if1.btnc = 1'b0;
    #2;
    check("reg_in_reset", if1.led, 9'h000);

    // Directed values with hand-computed results
    comb_vec("add_5_3",      16'h0305, 1'b0, 9'h008, 1'b1);
    comb_vec("add_pos_ovf",  16'h017F, 1'b0, 9'h180, 1'b1);
    comb_vec("add_neg_ovf",  16'h8080, 1'b0, 9'h100, 1'b1);
    comb_vec("sub_80_01",    16'h0180, 1'b1, 9'h17F, 1'b1);
    comb_vec("sub_00_80",    16'h8000, 1'b1, 9'h180, 1'b1);
    comb_vec("sub_05_05",    16'h0505, 1'b1, 9'h000, 1'b1);
    comb_vec("add_80_7f",    16'h7F80, 1'b0, 9'h0FF, 1'b1);

    for (int i = 0; i < 255; i++)
      comb_vec("comb_rand", 16'($urandom), i[0], 9'h000, 1'b0);

    check("reg_held_in_reset", if1.led, 9'h000);

    // Registered variant: release, 1-cycle latency
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reg_before_first_edge", if1.led, 9'h000);
    exp_q.push_back(model(if1.sw, if1.btnc));
    @(posedge clk);
    #1;
    pop_exp(e);
    check("reg_first_capture", if1.led, e);

    reg_vec("reg_pos_ovf", 16'h017F, 1'b0);
    reg_vec("reg_sub_ovf", 16'h0180, 1'b1);
    for (int i = 0; i < 8; i++)
      reg_vec("reg_rand", 16'($urandom), i[0]);

    // Mid-run reset: clears at once and discards the pending input
    @(negedge clk);
    if1.sw = 16'h8080; if1.btnc = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("reg_async_clear", if1.led, 9'h000);
    @(posedge clk);
    #1;
    check("reg_hold_zero", if1.led, 9'h000);
    @(negedge clk);
    if1.sw = 16'h0305;
    rst_n = 1'b1;
    exp_q.push_back(model(if1.sw, if1.btnc));
    @(posedge clk);
    #1;
    pop_exp(e);
    check("reg_after_rerelease", if1.led, e);

    if (exp_q.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
